// File: rtl/maxpool2_col.sv
// rtl/maxpool2_col.sv - column-streaming 2x2 FP16 max-pool with optional ReLU
module maxpool2_col #(
  parameter int DATA_WIDTH = 16,
  parameter int COL_SIZE   = 10,
  parameter int IMG_WIDTH  = 10,
  parameter int RELU_EN    = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clear,
  input  logic                                valid_in,
  input  logic [DATA_WIDTH*COL_SIZE-1:0]      in_column,
  output logic [DATA_WIDTH*(COL_SIZE/2)-1:0]  out_column,
  output logic                                valid_out,
  output logic                                frame_done
);

  localparam int HALF  = COL_SIZE / 2;
  localparam int CNT_W = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_COL  = CNT_W'(IMG_WIDTH - 1);
  // With an odd width the final column is dropped, so the last pair ends one column early.
  localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'((IMG_WIDTH % 2 == 0) ? IMG_WIDTH - 1 : IMG_WIDTH - 2);

  if (COL_SIZE % 2 != 0) begin : g_bad_col_size
    $error("maxpool2_col: COL_SIZE must be even");
  end
  if (IMG_WIDTH < 2) begin : g_bad_img_width
    $error("maxpool2_col: IMG_WIDTH must be at least 2");
  end

  typedef enum logic {EVEN, ODD} phase_t;

  function automatic logic [DATA_WIDTH-1:0] f_max(input logic [DATA_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b);
    logic                  sa, sb;
    logic [DATA_WIDTH-2:0] ma, mb;
    sa = a[DATA_WIDTH-1];
    sb = b[DATA_WIDTH-1];
    ma = a[DATA_WIDTH-2:0];
    mb = b[DATA_WIDTH-2:0];
    // Signed zeros tie regardless of sign, and ties keep the first operand.
    if (ma == '0 && mb == '0) return a;
    else if (sa != sb)        return sa ? b : a;
    else if (!sa)             return (mb > ma) ? b : a;
    else                      return (mb < ma) ? b : a;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] f_relu(input logic [DATA_WIDTH-1:0] x);
    if (RELU_EN != 0 && x[DATA_WIDTH-1]) return '0;
    else                                 return x;
  endfunction

  phase_t                           r_phase;
  logic [CNT_W-1:0]                 r_col_cnt;
  logic [HALF-1:0][DATA_WIDTH-1:0]  r_hold;
  logic [HALF-1:0][DATA_WIDTH-1:0]  r_out;
  logic                             r_valid;
  logic                             r_done;
  logic [HALF-1:0][DATA_WIDTH-1:0]  w_vmax;
  logic [HALF-1:0][DATA_WIDTH-1:0]  w_pool;

  for (genvar g = 0; g < HALF; g++) begin : g_lane
    assign w_vmax[g] = f_max(in_column[(2*g)*DATA_WIDTH +: DATA_WIDTH],
                             in_column[(2*g+1)*DATA_WIDTH +: DATA_WIDTH]);
    assign w_pool[g] = f_relu(f_max(r_hold[g], w_vmax[g]));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_phase   <= EVEN;
      r_col_cnt <= '0;
      r_hold    <= '0;
      r_out     <= '0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      if (clear) begin
        r_phase   <= EVEN;
        r_col_cnt <= '0;
        r_hold    <= '0;
      end else if (valid_in) begin
        r_col_cnt <= (r_col_cnt == LAST_COL) ? '0 : r_col_cnt + CNT_W'(1);
        case (r_phase)
          EVEN: begin
            // An EVEN column at the last position only occurs for odd widths and is dropped.
            if (r_col_cnt != LAST_COL) begin
              r_hold  <= w_vmax;
              r_phase <= ODD;
            end
          end
          ODD: begin
            r_out   <= w_pool;
            r_valid <= 1'b1;
            r_done  <= (r_col_cnt == LAST_PAIR);
            r_phase <= EVEN;
          end
          default: r_phase <= EVEN;
        endcase
      end
    end
  end

  assign out_column = r_out;
  assign valid_out  = r_valid;
  assign frame_done = r_done;

endmodule
